// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
//
// Takes one WIDTH-bit word over a valid/ready handshake and shifts it out
// MSB-first on seq_out, one bit per clock. seq_valid_o marks the cycles that
// carry a bit. done_o pulses for one cycle after the last bit. A programmable
// idle gap follows each word before ready_o reasserts.
//
// Build option: define SEQ_TX_MARKER_EN to send the sync marker 1,1,0 before
// every word. A downstream "110" detector can use it to frame words.
//
// Handshake: a word is accepted on a rising edge where valid_i and ready_o
// are both high. data_i is captured on that edge and does not have to be held
// afterwards. valid_i has no effect while ready_o is low.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_ni     asynchronous active-low reset
//   data_i       parallel word to transmit
//   valid_i      data_i is valid
//   ready_o      a word can be accepted this cycle (registered)
//   seq_out      serial data, MSB first (registered)
//   seq_valid_o  seq_out carries a payload or marker bit (registered)
//   done_o       one-cycle pulse after the last bit of a word (registered)
//   busy_o       state is not IDLE (decoded from the state register)
module seq_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             seq_out,
  output logic             seq_valid_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  // The gap counter is loaded with GAP_CYCLES-1, so clog2(GAP_CYCLES) bits are enough.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_GAP
`ifdef SEQ_TX_MARKER_EN
    , S_MARK
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             ready_q, ready_d;
  logic             seq_q, seq_d;
  logic             sval_q, sval_d;
  logic             done_q, done_d;
`ifdef SEQ_TX_MARKER_EN
  logic [1:0]       mark_cnt_q, mark_cnt_d;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      ready_q    <= 1'b0;
      seq_q      <= IDLE_LEVEL;
      sval_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SEQ_TX_MARKER_EN
      mark_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ready_q    <= ready_d;
      seq_q      <= seq_d;
      sval_q     <= sval_d;
      done_q     <= done_d;
`ifdef SEQ_TX_MARKER_EN
      mark_cnt_q <= mark_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ready_d    = ready_q;
    seq_d      = seq_q;
    sval_d     = sval_q;
    done_d     = 1'b0;
`ifdef SEQ_TX_MARKER_EN
    mark_cnt_d = mark_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        seq_d   = IDLE_LEVEL;
        sval_d  = 1'b0;
        if (valid_i && ready_q) begin
          shreg_d = data_i;
          ready_d = 1'b0;
          sval_d  = 1'b1;
`ifdef SEQ_TX_MARKER_EN
          // The first marker bit goes out now. The word waits in shreg.
          state_d    = S_MARK;
          seq_d      = 1'b1;
          mark_cnt_d = 2'd0;
`else
          state_d   = S_SHIFT;
          seq_d     = data_i[WIDTH-1];
          bit_cnt_d = CW'(WIDTH - 1);
`endif
        end
      end
`ifdef SEQ_TX_MARKER_EN
      S_MARK: begin
        case (mark_cnt_q)
          2'd0: begin
            seq_d      = 1'b1;
            mark_cnt_d = 2'd1;
          end
          2'd1: begin
            seq_d      = 1'b0;
            mark_cnt_d = 2'd2;
          end
          default: begin
            // The data MSB follows the marker's 0 directly, with no bubble.
            seq_d     = shreg_q[WIDTH-1];
            bit_cnt_d = CW'(WIDTH - 1);
            state_d   = S_SHIFT;
          end
        endcase
      end
`endif
      S_SHIFT: begin
        if (bit_cnt_q == '0) begin
          // The last bit has now been on the line for one full cycle.
          seq_d   = IDLE_LEVEL;
          sval_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          seq_d     = shreg_q[WIDTH-2];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (GAP_CYCLES > 0) begin
          state_d   = S_GAP;
          gap_cnt_d = GW'(GAP_LOAD);
        end else begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready_o     = ready_q;
  assign seq_out     = seq_q;
  assign seq_valid_o = sval_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
